// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths and forward-select encoding for the ID/EX operand stage.
// Width defaults come from WORD_LEN / REG_FILE_ADDR_LEN / ALU_CMD_LEN macros when predefined.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef ALU_CMD_LEN
`define ALU_CMD_LEN 4
`endif

package id_ex_operand_stage_pkg;

   localparam int WORD_LEN_DEF     = `WORD_LEN;
   localparam int REG_ADDR_LEN_DEF = `REG_FILE_ADDR_LEN;
   localparam int ALU_CMD_LEN_DEF  = `ALU_CMD_LEN;

   typedef enum logic [1:0] {
      FWD_SEL_REG   = 2'b00,
      FWD_SEL_EXMEM = 2'b01,
      FWD_SEL_MEMWB = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_hazard_forward_unit.sv
// Combinational load-use detection and per-operand forward selection.
module hazard_forward_unit
   import id_ex_operand_stage_pkg::*;
#(
   parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF
) (
   input  logic [REG_ADDR_LEN-1:0] id_rs,
   input  logic [REG_ADDR_LEN-1:0] id_rt,
   input  logic                    id_uses_rs,
   input  logic                    id_uses_rt,
   input  logic                    ex_valid,
   input  logic                    ex_mem_read,
   input  logic [REG_ADDR_LEN-1:0] ex_rd,
   input  logic [REG_ADDR_LEN-1:0] ex_rs,
   input  logic [REG_ADDR_LEN-1:0] ex_rt,
   input  logic                    exmem_reg_write,
   input  logic [REG_ADDR_LEN-1:0] exmem_rd,
   input  logic                    memwb_reg_write,
   input  logic [REG_ADDR_LEN-1:0] memwb_rd,
   output logic                    load_use,
   output fwd_sel_e                fwd_a,
   output fwd_sel_e                fwd_b
);

   logic exmem_live, memwb_live;
   logic a_exmem, a_memwb, b_exmem, b_memwb;

   // A nonzero destination check here is what keeps r0 from ever forwarding.
   assign exmem_live = exmem_reg_write && (exmem_rd != '0);
   assign memwb_live = memwb_reg_write && (memwb_rd != '0);

   assign a_exmem = exmem_live && (exmem_rd == ex_rs);
   assign a_memwb = memwb_live && (memwb_rd == ex_rs);
   assign b_exmem = exmem_live && (exmem_rd == ex_rt);
   assign b_memwb = memwb_live && (memwb_rd == ex_rt);

   assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

   always_comb begin
      fwd_a = FWD_SEL_REG;
      fwd_b = FWD_SEL_REG;
      if (a_exmem)      fwd_a = FWD_SEL_EXMEM;
      else if (a_memwb) fwd_a = FWD_SEL_MEMWB;
      if (b_exmem)      fwd_b = FWD_SEL_EXMEM;
      else if (b_memwb) fwd_b = FWD_SEL_MEMWB;
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubbles and EX-side operand forwarding.
// Optional ID_WB_BYPASS_EN: latch MEM/WB result at ID when it targets rs/rt.
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int WORD_LEN     = WORD_LEN_DEF,
   parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
   parameter int ALU_CMD_LEN  = ALU_CMD_LEN_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hold,
   input  logic                    flush,
   input  logic                    id_valid,
   input  logic [REG_ADDR_LEN-1:0] id_rs,
   input  logic [REG_ADDR_LEN-1:0] id_rt,
   input  logic [REG_ADDR_LEN-1:0] id_rd,
   input  logic [WORD_LEN-1:0]     id_reg1,
   input  logic [WORD_LEN-1:0]     id_reg2,
   input  logic [WORD_LEN-1:0]     id_imm,
   input  logic                    id_uses_rs,
   input  logic                    id_uses_rt,
   input  logic                    id_alu_src,
   input  logic [ALU_CMD_LEN-1:0]  id_alu_cmd,
   input  logic                    id_mem_read,
   input  logic                    id_mem_write,
   input  logic                    id_reg_write,
   input  logic                    exmem_reg_write,
   input  logic [REG_ADDR_LEN-1:0] exmem_rd,
   input  logic [WORD_LEN-1:0]     exmem_result,
   input  logic                    memwb_reg_write,
   input  logic [REG_ADDR_LEN-1:0] memwb_rd,
   input  logic [WORD_LEN-1:0]     memwb_result,
   output logic                    stall,
   output logic                    ex_valid,
   output logic                    ex_mem_read,
   output logic                    ex_mem_write,
   output logic                    ex_reg_write,
   output logic [REG_ADDR_LEN-1:0] ex_rd,
   output logic [ALU_CMD_LEN-1:0]  ex_alu_cmd,
   output logic [WORD_LEN-1:0]     ex_op_a,
   output logic [WORD_LEN-1:0]     ex_op_b,
   output logic [WORD_LEN-1:0]     ex_store_data
);

   logic [REG_ADDR_LEN-1:0] ex_rs, ex_rt;
   logic [WORD_LEN-1:0]     ex_reg1, ex_reg2, ex_imm;
   logic                    ex_alu_src;
   logic                    load_use, bubble;
   fwd_sel_e                fwd_a, fwd_b;
   logic [WORD_LEN-1:0]     id_val1, id_val2, fwd_val_a, fwd_val_b;

   hazard_forward_unit #(
      .REG_ADDR_LEN (REG_ADDR_LEN)
   ) u_hfu (
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_valid        (ex_valid),
      .ex_mem_read     (ex_mem_read),
      .ex_rd           (ex_rd),
      .ex_rs           (ex_rs),
      .ex_rt           (ex_rt),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .load_use        (load_use),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b)
   );

`ifdef ID_WB_BYPASS_EN
   assign id_val1 = (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs)) ? memwb_result : id_reg1;
   assign id_val2 = (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rt)) ? memwb_result : id_reg2;
`else
   // Same-cycle WB data already visible through the register file's negedge write.
   assign id_val1 = id_reg1;
   assign id_val2 = id_reg2;
`endif

   // Flush suppresses the stall: the squashed consumer must not freeze fetch.
   assign stall  = rst & (hold | (id_valid & load_use & ~flush));
   assign bubble = flush | load_use | ~id_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid     <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_rd        <= '0;
         ex_alu_cmd   <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         ex_reg1      <= '0;
         ex_reg2      <= '0;
         ex_imm       <= '0;
         ex_alu_src   <= 1'b0;
      end else if (!hold) begin
         if (bubble) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_rd        <= '0;
            ex_alu_cmd   <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_reg1      <= '0;
            ex_reg2      <= '0;
            ex_imm       <= '0;
            ex_alu_src   <= 1'b0;
         end else begin
            ex_valid     <= 1'b1;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_reg_write <= id_reg_write;
            ex_rd        <= id_rd;
            ex_alu_cmd   <= id_alu_cmd;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_reg1      <= id_val1;
            ex_reg2      <= id_val2;
            ex_imm       <= id_imm;
            ex_alu_src   <= id_alu_src;
         end
      end
   end

   always_comb begin
      fwd_val_a = ex_reg1;
      case (fwd_a)
         FWD_SEL_EXMEM: fwd_val_a = exmem_result;
         FWD_SEL_MEMWB: fwd_val_a = memwb_result;
         default:       fwd_val_a = ex_reg1;
      endcase
   end

   always_comb begin
      fwd_val_b = ex_reg2;
      case (fwd_b)
         FWD_SEL_EXMEM: fwd_val_b = exmem_result;
         FWD_SEL_MEMWB: fwd_val_b = memwb_result;
         default:       fwd_val_b = ex_reg2;
      endcase
   end

   assign ex_op_a       = fwd_val_a;
   assign ex_op_b       = ex_alu_src ? ex_imm : fwd_val_b;
   assign ex_store_data = fwd_val_b;

endmodule
